// File: rtl/noise_generator.sv
// noise_generator: SN76489-style noise channel, a rate divider or tone-3 edge clocks
// a Fibonacci LFSR in periodic or white-noise mode.
module noise_generator #(
    parameter int LFSR_WIDTH = 15,
    parameter int TAP_WHITE = 1,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED = {1'b1, {(LFSR_WIDTH-1){1'b0}}}
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       wr,
    input  logic [2:0] wr_data,
    input  logic       tone3_in,
    output logic       snd_out
);
    logic [2:0] ctrl;
    logic [6:0] cnt;
    logic phase, t3_q, ext, wrap, shift, fb;
    logic [LFSR_WIDTH-1:0] lfsr;
    always_comb begin
        ext = &ctrl[1:0];
        wrap = cnt == 7'd1;
        shift = ext ? (tone3_in && !t3_q) : (ce && wrap && !phase);
        fb = ctrl[2] ? lfsr[0] ^ lfsr[TAP_WHITE] : lfsr[0];
    end
    // NF=3 reloads to zero, but the divider is idle in that mode until the next write
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= '0;
            cnt <= 7'd16;
            phase <= 1'b0;
            t3_q <= 1'b0;
            lfsr <= LFSR_SEED;
        end else begin
            t3_q <= tone3_in;
            if (wr) begin
                ctrl <= wr_data;
                cnt <= 7'd16 << wr_data[1:0];
                phase <= 1'b0;
                lfsr <= LFSR_SEED;
            end else begin
                if (ce && !ext) begin
                    cnt <= wrap ? 7'd16 << ctrl[1:0] : cnt - 7'd1;
                    phase <= wrap ? ~phase : phase;
                end
                if (shift)
                    lfsr <= {fb, lfsr[LFSR_WIDTH-1:1]};
            end
        end
    end
    assign snd_out = lfsr[0];
endmodule

// File: tb/tb_noise_generator.sv
// tb_noise_generator: randomized scoreboard bench for noise_generator against a shift-schedule reference model
module tb_noise_generator;
  logic clk = 1'b0;
  logic rst = 1'b1, ce = 1'b0, wr = 1'b0, tone3_in = 1'b0;
  logic [2:0] wr_data = 3'b000;
  logic snd_out;
  int n_cmp = 0, n_bad = 0, n_cyc = 0;
  bit exp_q[$];
  logic [2:0] m_ctrl;
  int ticks, k;
  logic [14:0] lf;
  bit prev;
  bit done = 1'b0;
  localparam logic [14:0] SEED = 15'h4000;
  noise_generator dut (
    .clk(clk), .rst(rst), .ce(ce), .wr(wr),
    .wr_data(wr_data), .tone3_in(tone3_in), .snd_out(snd_out)
  );
  always #5 clk = ~clk;
  task automatic step(input bit r, input bit w, input logic [2:0] d, input bit c, input bit t);
    bit sh;
    int rl;
    @(negedge clk);
    rst = r; wr = w; wr_data = d; ce = c; tone3_in = t;
    n_cyc++;
    sh = 1'b0;
    if (r) begin
      m_ctrl = 3'b000; ticks = 0; k = 0; lf = SEED; prev = 1'b0;
    end else begin
      if (w) begin
        m_ctrl = d; ticks = 0; k = 0; lf = SEED;
      end else if (m_ctrl[1:0] != 2'b11) begin
        if (c) begin
          ticks++;
          rl = 16 << m_ctrl[1:0];
          sh = (ticks % (2 * rl)) == rl;
        end
      end else begin
        sh = t && !prev;
      end
      prev = t;
      if (sh) begin
        k++;
        lf = {lf[0] ^ (m_ctrl[2] & lf[1]), lf[14:1]};
      end
    end
    exp_q.push_back(m_ctrl[2] ? bit'(lf[0]) : ((k % 15) == 14));
  endtask
  task automatic chk_rst();
    @(posedge clk);
    #2;
    n_cmp++;
    if (snd_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset state cycle %0d: snd_out=%b expected 0", n_cyc, snd_out);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      bit e;
      e = exp_q.pop_front();
      n_cmp++;
      if (snd_out !== e) begin
        n_bad++;
        $display("FAIL snd_out cycle %0d: got %b expected %b", n_cyc, snd_out, e);
      end
    end
  end
  initial begin
    #5ms;
    if (!done) begin
      n_bad++;
      $display("FAIL timeout: stimulus did not complete, %0d cycles run", n_cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end
  initial begin
    step(1, 0, 3'b000, 0, 0);
    step(1, 0, 3'b000, 1, 1);
    chk_rst();
    step(0, 1, 3'b000, 0, 0);
    repeat (1000) step(0, 0, 3'b000, 1, 0);
    for (int nf = 0; nf < 3; nf++) begin
      step(0, 1, {1'b1, 2'(nf)}, 1, 0);
      repeat (2500) step(0, 0, 3'b000, ($urandom % 4) != 0, bit'($urandom_range(1, 0)));
    end
    step(0, 1, 3'b011, 0, 0);
    for (int i = 0; i < 600; i++) step(0, 0, 3'b000, 0, bit'((i / 5) % 2));
    step(0, 1, 3'b111, 0, 0);
    for (int i = 0; i < 8000; i++) step(0, 0, 3'b000, bit'($urandom_range(1, 0)), bit'(i % 2));
    repeat (150) step(0, 0, 3'b000, 1, 1);
    step(0, 1, 3'b001, 1, 0);
    repeat (200) step(0, 0, 3'b000, 1, 0);
    step(0, 1, 3'b100, 1, 0);
    repeat (500) step(0, 0, 3'b000, 1, 0);
    step(1, 1, 3'b101, 1, 1);
    chk_rst();
    repeat (600) step(0, 0, 3'b000, 1, bit'($urandom_range(1, 0)));
    for (int i = 0; i < 30000; i++)
      step(($urandom % 500) == 0, ($urandom % 200) == 0, 3'($urandom),
           ($urandom % 3) != 0, bit'($urandom_range(1, 0)));
    @(posedge clk);
    #2;
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
